// File: rtl/mem2d_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem2d_arb_pkg
// Brief  : Shared widths and FSM state type for the 2-D memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem2d_arb_pkg;

    localparam int MEM2D_XW = 6;
    localparam int MEM2D_YW = 5;
    localparam int MEM2D_DW = 8;
    localparam int MEM2D_AW = MEM2D_XW + MEM2D_YW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem2d_state_t;

endpackage
`default_nettype wire

// File: rtl/mem2d_arb_if.sv
`default_nettype none
// ============================================================================
// Module : mem2d_arb_if
// Brief  : Two-requester access bus, read response and clear control.
// Rev    : 1.0  initial release
// ============================================================================
interface mem2d_arb_if;
    import mem2d_arb_pkg::*;

    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic                req0_wr,    req1_wr;
    logic [MEM2D_XW-1:0] req0_x,     req1_x;
    logic [MEM2D_YW-1:0] req0_y,     req1_y;
    logic [MEM2D_DW-1:0] req0_wdata, req1_wdata;
    logic                rsp0_valid, rsp1_valid;
    logic [MEM2D_DW-1:0] rsp_rdata;
    logic                clr_start;
    logic                clr_busy;
    logic                clr_done;

    modport master (
        output req0_valid, req1_valid, req0_wr, req1_wr, req0_x, req1_x,
               req0_y, req1_y, req0_wdata, req1_wdata, clr_start,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               clr_busy, clr_done
    );

    modport slave (
        input  req0_valid, req1_valid, req0_wr, req1_wr, req0_x, req1_x,
               req0_y, req1_y, req0_wdata, req1_wdata, clr_start,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               clr_busy, clr_done
    );

endinterface
`default_nettype wire

// File: rtl/mem2d_sync.sv
`default_nettype none
// ============================================================================
// Module : mem2d_sync
// Brief  : 64x32x8 single-port storage, write on edge, registered read.
// Rev    : 1.0  initial release
// ============================================================================
module mem2d_sync
    import mem2d_arb_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                wr,
    input  wire logic [MEM2D_XW-1:0] x,
    input  wire logic [MEM2D_YW-1:0] y,
    input  wire logic [MEM2D_DW-1:0] wdata,
    output logic      [MEM2D_DW-1:0] rdata
);

    logic [MEM2D_DW-1:0] r_mem [0:(2**MEM2D_AW)-1];
    logic [MEM2D_DW-1:0] r_rdata;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[{x, y}] <= wdata;
        end
        r_rdata <= r_mem[{x, y}];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem2d_arb.sv
`default_nettype none
// ============================================================================
// Module : mem2d_arb
// Brief  : Round-robin two-port arbiter over mem2d_sync with a full-array
//          clear engine, built only when MEM2D_ARB_CLEAR_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module mem2d_arb
    import mem2d_arb_pkg::*;
#(
    parameter logic [MEM2D_DW-1:0] CLR_VAL = 8'h00
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mem2d_arb_if.slave bus
);

    mem2d_state_t        r_state, w_state_nxt;
    logic                r_last;
    logic                r_rsp0, r_rsp1;
    logic [MEM2D_DW-1:0] r_hold;
    logic                w_clr_go, w_clr_last, w_clr_done;
    logic [MEM2D_AW-1:0] w_clr_addr;
    logic                w_blocked, w_gnt0, w_gnt1;
    logic                w_mem_wr;
    logic [MEM2D_XW-1:0] w_mem_x;
    logic [MEM2D_YW-1:0] w_mem_y;
    logic [MEM2D_DW-1:0] w_mem_wdata, w_mem_rdata;

`ifdef MEM2D_ARB_CLEAR_EN
    logic [MEM2D_AW-1:0] r_clr_addr;
    logic                r_clr_done;

    assign w_clr_go   = bus.clr_start && (r_state == IDLE);
    assign w_clr_addr = r_clr_addr;
    assign w_clr_last = (r_state == CLEAR) && (&r_clr_addr);
    assign w_clr_done = r_clr_done;

    // Address is {x,y}, so a plain increment walks y fastest then x.
    always_ff @(posedge clk) begin
        if (rst || r_state != CLEAR) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
        r_clr_done <= !rst && w_clr_last;
    end
`else
    logic w_unused_clr_start;

    assign w_unused_clr_start = bus.clr_start;
    assign w_clr_go           = 1'b0;
    assign w_clr_addr         = '0;
    assign w_clr_last         = 1'b0;
    assign w_clr_done         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_clr_go)   w_state_nxt = CLEAR;
            CLEAR:   if (w_clr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_last = 1 means requester 1 was granted most recently.
    assign w_blocked = rst || (r_state == CLEAR) || w_clr_go;
    assign w_gnt0    = !w_blocked && bus.req0_valid && (!bus.req1_valid ||  r_last);
    assign w_gnt1    = !w_blocked && bus.req1_valid && (!bus.req0_valid || !r_last);

    always_comb begin
        w_mem_wr    = w_gnt1 && bus.req1_wr;
        w_mem_x     = bus.req1_x;
        w_mem_y     = bus.req1_y;
        w_mem_wdata = bus.req1_wdata;
        if (r_state == CLEAR) begin
            w_mem_wr    = !rst;
            w_mem_x     = w_clr_addr[MEM2D_AW-1:MEM2D_YW];
            w_mem_y     = w_clr_addr[MEM2D_YW-1:0];
            w_mem_wdata = CLR_VAL;
        end else if (w_gnt0) begin
            w_mem_wr    = bus.req0_wr;
            w_mem_x     = bus.req0_x;
            w_mem_y     = bus.req0_y;
            w_mem_wdata = bus.req0_wdata;
        end
    end

    mem2d_sync u_mem (
        .clk   (clk),
        .wr    (w_mem_wr),
        .x     (w_mem_x),
        .y     (w_mem_y),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
            r_hold <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
            r_rsp0 <= w_gnt0 && !bus.req0_wr;
            r_rsp1 <= w_gnt1 && !bus.req1_wr;
            if (r_rsp0 || r_rsp1) begin
                r_hold <= w_mem_rdata;
            end
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp0_valid = !rst && r_rsp0;
    assign bus.rsp1_valid = !rst && r_rsp1;
    assign bus.rsp_rdata  = rst ? '0 : ((r_rsp0 || r_rsp1) ? w_mem_rdata : r_hold);
    assign bus.clr_busy   = !rst && (r_state == CLEAR);
    assign bus.clr_done   = !rst && w_clr_done;

endmodule
`default_nettype wire

// File: tb/tb_mem2d_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem2d_arb
// Brief  : Randomized and directed bench for mem2d_arb with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem2d_arb;
    import mem2d_arb_pkg::*;

    localparam logic [7:0] c_CLR = 8'h5A;
`ifdef MEM2D_ARB_CLEAR_EN
    localparam bit c_CLR_EN = 1'b1;
`else
    localparam bit c_CLR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem2d_arb_if bus ();

    mem2d_arb #(.CLR_VAL(c_CLR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents plus which cells hold a known value.
    logic [7:0] mm [64][32];
    bit         mk [64][32];
    bit         m_last = 1'b1;
    bit         m_clr  = 1'b0;
    bit         m_done = 1'b0;
    int         m_idx  = 0;
    int         m_pend = -1;
    logic [7:0] m_pd   = 8'h00;
    bit         m_pk   = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_hk   = 1'b1;

    always @(negedge clk) begin
        bit         blk, e0, e1, wr;
        logic [5:0] x;
        logic [4:0] y;
        logic [7:0] wd;
        if (rst) begin
            chk("rst_ready0", 32'(bus.req0_ready), 0);
            chk("rst_ready1", 32'(bus.req1_ready), 0);
            chk("rst_rsp0",   32'(bus.rsp0_valid), 0);
            chk("rst_rsp1",   32'(bus.rsp1_valid), 0);
            chk("rst_rdata",  32'(bus.rsp_rdata),  0);
            chk("rst_busy",   32'(bus.clr_busy),   0);
            chk("rst_done",   32'(bus.clr_done),   0);
            m_last = 1'b1; m_clr = 1'b0; m_done = 1'b0; m_pend = -1;
            m_hold = 8'h00; m_hk = 1'b1;
        end else begin
            blk = m_clr || (c_CLR_EN && bus.clr_start);
            e0  = !blk && bus.req0_valid && (!bus.req1_valid || m_last);
            e1  = !blk && bus.req1_valid && (!bus.req0_valid || !m_last);
            chk("ready0", 32'(bus.req0_ready), 32'(e0));
            chk("ready1", 32'(bus.req1_ready), 32'(e1));
            chk("busy",   32'(bus.clr_busy),   32'(m_clr));
            chk("done",   32'(bus.clr_done),   32'(m_done));
            chk("rsp0",   32'(bus.rsp0_valid), 32'(m_pend == 0));
            chk("rsp1",   32'(bus.rsp1_valid), 32'(m_pend == 1));
            if (m_pend >= 0) begin
                if (m_pk) chk("rdata", 32'(bus.rsp_rdata), 32'(m_pd));
                m_hold = m_pd; m_hk = m_pk;
            end else if (m_hk) begin
                chk("rdata_hold", 32'(bus.rsp_rdata), 32'(m_hold));
            end
            m_pend = -1;
            m_done = 1'b0;
            if (m_clr) begin
                mm[m_idx / 32][m_idx % 32] = c_CLR;
                mk[m_idx / 32][m_idx % 32] = 1'b1;
                m_idx++;
                if (m_idx == 2048) begin
                    m_clr = 1'b0; m_done = 1'b1;
                end
            end else if (c_CLR_EN && bus.clr_start) begin
                m_clr = 1'b1; m_idx = 0;
            end
            if (e0 || e1) begin
                wr = e0 ? bus.req0_wr    : bus.req1_wr;
                x  = e0 ? bus.req0_x     : bus.req1_x;
                y  = e0 ? bus.req0_y     : bus.req1_y;
                wd = e0 ? bus.req0_wdata : bus.req1_wdata;
                m_last = e1;
                if (wr) begin
                    mm[x][y] = wd; mk[x][y] = 1'b1;
                end else begin
                    m_pend = e1 ? 1 : 0; m_pd = mm[x][y]; m_pk = mk[x][y];
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_wr    = 1'b0; bus.req1_wr    = 1'b0;
        bus.clr_start  = 1'b0;
    endtask

    task automatic acc0(input bit wr, input int x, input int y, input int d);
        bus.req0_valid = 1'b1; bus.req0_wr = wr;
        bus.req0_x = 6'(x); bus.req0_y = 5'(y); bus.req0_wdata = 8'(d);
    endtask

    task automatic acc1(input bit wr, input int x, input int y, input int d);
        bus.req1_valid = 1'b1; bus.req1_wr = wr;
        bus.req1_x = 6'(x); bus.req1_y = 5'(y); bus.req1_wdata = 8'(d);
    endtask

    initial begin
        int nb, nr, nd;
        bit seen;
        quiet();
        bus.req0_x = '0; bus.req0_y = '0; bus.req0_wdata = '0;
        bus.req1_x = '0; bus.req1_y = '0; bus.req1_wdata = '0;
        adv();
        acc0(1'b0, 0, 0, 0);
        @(negedge clk);
        chk("lit_rst_ready0", 32'(bus.req0_ready), 0);
        adv();
        rst = 1'b0;

        // Contention straight after reset: 0, 1, 0.
        acc0(1'b0, 0, 0, 0); acc1(1'b0, 0, 0, 0);
        @(negedge clk); chk("lit_cont1_r0", 32'(bus.req0_ready), 1); chk("lit_cont1_r1", 32'(bus.req1_ready), 0);
        adv();
        @(negedge clk); chk("lit_cont2_r0", 32'(bus.req0_ready), 0); chk("lit_cont2_r1", 32'(bus.req1_ready), 1);
        adv();
        @(negedge clk); chk("lit_cont3_r0", 32'(bus.req0_ready), 1); chk("lit_cont3_r1", 32'(bus.req1_ready), 0);
        adv(); quiet(); adv();

        // Write then read back.
        acc0(1'b1, 5, 7, 8'hA5);
        @(negedge clk); chk("lit_wr_ready", 32'(bus.req0_ready), 1);
        adv(); acc0(1'b0, 5, 7, 0);
        adv(); quiet();
        @(negedge clk); chk("lit_rd_valid", 32'(bus.rsp0_valid), 1); chk("lit_rd_data", 32'(bus.rsp_rdata), 32'h A5);
        adv();
        @(negedge clk); chk("lit_rd_after", 32'(bus.rsp0_valid), 0); chk("lit_rd_holds", 32'(bus.rsp_rdata), 32'h A5);
        adv();

`ifdef MEM2D_ARB_CLEAR_EN
        // Full sweep with requester 0 waiting on (63,31).
        acc1(1'b1, 63, 31, 8'h3C); adv(); quiet();
        bus.clr_start = 1'b1; adv(); bus.clr_start = 1'b0;
        acc0(1'b0, 63, 31, 0);
        nb = 0; nr = 0; nd = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (bus.clr_busy) nb++;
            if (bus.clr_busy && (bus.req0_ready || bus.req1_ready)) nr++;
            if (bus.clr_done) begin
                nd++;
                break;
            end
            adv();
        end
        chk("lit_sweep_done_seen", 32'(nd), 1);
        chk("lit_sweep_busy_cycles", 32'(nb), 2048);
        chk("lit_sweep_ready_low", 32'(nr), 0);
        chk("lit_done_busy_low", 32'(bus.clr_busy), 0);
        chk("lit_done_grant", 32'(bus.req0_ready), 1);
        adv(); quiet();
        @(negedge clk);
        chk("lit_done_single", 32'(bus.clr_done), 0);
        chk("lit_clr_rd_valid", 32'(bus.rsp0_valid), 1);
        chk("lit_clr_rd_data", 32'(bus.rsp_rdata), 32'(c_CLR));
        adv();

        // Clear start together with a request from requester 1.
        bus.clr_start = 1'b1; acc1(1'b0, 1, 1, 0);
        @(negedge clk); chk("lit_sim_ready1", 32'(bus.req1_ready), 0);
        adv(); bus.clr_start = 1'b0;
        nr = 0; seen = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (bus.clr_done) begin
                seen = 1'b1;
                chk("lit_sim_done_grant", 32'(bus.req1_ready), 1);
                break;
            end
            if (bus.req1_ready) nr++;
            adv();
        end
        chk("lit_sim_done_seen", 32'(seen), 1);
        chk("lit_sim_blocked", 32'(nr), 0);
        adv(); quiet(); adv();

        // Reset at sweep cycle 100.
        acc0(1'b1, 0, 0, 8'h11); adv();
        acc0(1'b1, 63, 31, 8'h77); adv(); quiet();
        bus.clr_start = 1'b1; adv(); bus.clr_start = 1'b0;
        repeat (100) adv();
        rst = 1'b1; adv(); rst = 1'b0;
        @(negedge clk); chk("lit_abort_busy", 32'(bus.clr_busy), 0);
        nd = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (bus.clr_done || bus.clr_busy) nd++;
            adv();
        end
        chk("lit_abort_no_done", 32'(nd), 0);
        acc0(1'b0, 0, 0, 0); adv(); quiet();
        @(negedge clk); chk("lit_abort_00", 32'(bus.rsp_rdata), 32'(c_CLR));
        adv(); acc0(1'b0, 63, 31, 0); adv(); quiet();
        @(negedge clk); chk("lit_abort_6331", 32'(bus.rsp_rdata), 32'h77);
        adv();
`else
        bus.clr_start = 1'b1; acc0(1'b0, 2, 2, 0);
        @(negedge clk);
        chk("lit_noclr_grant", 32'(bus.req0_ready), 1);
        chk("lit_noclr_busy0", 32'(bus.clr_busy), 0);
        adv(); quiet();
        @(negedge clk);
        chk("lit_noclr_busy1", 32'(bus.clr_busy), 0);
        chk("lit_noclr_done", 32'(bus.clr_done), 0);
        adv();
`endif

        // Random traffic over a small address set to force collisions.
        for (int n = 0; n < 3000; n++) begin
            bus.req0_valid = ($urandom % 3) != 0;
            bus.req1_valid = ($urandom % 3) != 0;
            bus.req0_wr    = 1'($urandom % 2);
            bus.req1_wr    = 1'($urandom % 2);
            bus.req0_x     = (($urandom % 4) == 0) ? 6'd63 : 6'($urandom_range(0, 2));
            bus.req1_x     = (($urandom % 4) == 0) ? 6'd63 : 6'($urandom_range(0, 2));
            bus.req0_y     = 5'($urandom_range(0, 3));
            bus.req1_y     = 5'($urandom_range(0, 3));
            bus.req0_wdata = 8'($urandom);
            bus.req1_wdata = 8'($urandom);
            bus.clr_start  = ($urandom % 1500) == 0;
            rst            = ($urandom % 700) == 0;
            adv();
        end
        rst = 1'b0; quiet();
        repeat (3) adv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem2d_arb.md
MEM2D_ARB -- requirements
Module: mem2d_arb

Interface
REQ-001 Parameter CLR_VAL, default 8'h00: byte written to every location by the clear engine.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  in  1 each  requester N has a pending access.
REQ-005 req0_ready, req1_ready  out  1 each  access accepted this cycle.
REQ-006 req0_wr, req1_wr  in  1 each  1 = write, 0 = read.
REQ-007 req0_x, req1_x  in  6 each  column address, 0..63.
REQ-008 req0_y, req1_y  in  5 each  row address, 0..31.
REQ-009 req0_wdata, req1_wdata  in  8 each  write data.
REQ-010 rsp0_valid, rsp1_valid  out  1 each  read data valid for requester N.
REQ-011 rsp_rdata  out  8  read data, shared by both response strobes.
REQ-012 clr_start  in  1  one-cycle pulse that starts a full-array clear.
REQ-013 clr_busy  out  1  clear sweep in progress.
REQ-014 clr_done  out  1  one-cycle pulse after the last clear write.

Function
REQ-015 The block shall own a 64x32x8 synchronous memory: writes commit on the edge; read data appears one cycle after acceptance.
REQ-016 At most one access shall be accepted per cycle.
- reqN_ready is combinational.
- An access transfers when reqN_valid and reqN_ready are both 1.
REQ-017 With exactly one requester valid and no clear in progress, that requester shall be granted.
REQ-018 With both requesters valid, the requester not granted most recently shall win (round-robin).
- The last-grant pointer updates only on a transfer.
REQ-019 An accepted read shall assert rspN_valid for exactly one cycle, one cycle after acceptance.
- rsp_rdata carries the addressed byte in that cycle.
- rsp_rdata holds its value otherwise.
REQ-020 An accepted write shall produce no response.
- A read of the same location accepted in the following cycle shall return the new data.
REQ-021 FSM states shall be IDLE and CLEAR.
- IDLE -> CLEAR when clr_start = 1.
- CLEAR -> IDLE after writing address x=63, y=31.
REQ-022 In CLEAR, the block shall write CLR_VAL once per cycle, y incrementing fastest then x, from (0,0) to (63,31): 2048 cycles.
REQ-023 In CLEAR, both reqN_ready shall be 0 and clr_busy shall be 1.
- clr_start received during CLEAR shall be ignored.
REQ-024 clr_done shall pulse in the cycle after the final clear write, with clr_busy already 0.
- Requests may be granted in that same cycle.
REQ-025 If clr_start and reqN_valid are asserted together in IDLE, the request shall not be granted.
- The clear takes priority and begins that cycle.
REQ-026 A read accepted in the cycle before the clear starts shall still deliver its response.

Reset
REQ-027 When rst = 1, the block shall enter IDLE and drive these values:
- reqN_ready = 0.
- rspN_valid = 0.
- rsp_rdata = 8'h00.
- clr_busy = 0.
- clr_done = 0.
REQ-028 Reset shall set the last-grant pointer to requester 1, so requester 0 wins the first contention.
REQ-029 Reset shall not alter memory contents.
- Reset during CLEAR aborts the sweep, leaving it partially complete, with no clr_done.
- A pending read response is dropped.

Configuration
REQ-030 Macro MEM2D_ARB_CLEAR_EN shall select whether the clear engine is built.
- Defined: the clear engine and the CLEAR state shall be present.
- Undefined: clr_busy and clr_done shall be tied to 0, clr_start shall be ignored, and the FSM shall remain in IDLE.

Structure
REQ-031 A shared package shall hold:
- Constants MEM2D_XW=6, MEM2D_YW=5, MEM2D_DW=8.
- The FSM state enum (IDLE, CLEAR).
REQ-032 The storage shall be a single sub-module, mem2d_sync.
- Ports: clk, wr, x, y, wdata, rdata; registered read.
- Arbitration and the FSM live in mem2d_arb.

Verification
REQ-033 The bench shall cover these scenarios:
- Single write then read: req0 writes 8'hA5 at (5,7), then reads (5,7) -> rsp0_valid one cycle later, rsp_rdata = 8'hA5.
- Contention after reset: both valid reading (0,0) -> req0 granted cycle 1, req1 cycle 2, req0 cycle 3 while both stay valid.
- Clear sweep: write 8'h3C at (63,31); pulse clr_start -> clr_busy high for 2048 cycles, ready low throughout, clr_done one pulse; read (63,31) = CLR_VAL.
- Simultaneous start: clr_start with req1_valid -> req1_ready = 0 until clr_done; req1 is granted in the clr_done cycle.
- Reset mid-clear: rst at sweep cycle 100 -> clr_busy = 0 next cycle, no clr_done; (0,0) = CLR_VAL; (63,31) keeps its prior value.
- Macro undefined: clr_start pulse -> clr_busy stays 0 and requests are granted normally.
